matrix_datapath: RTL and testbench

//  Matrix execute datapath of the matrix processor: instruction decoder, matrix register

---
 rtl/matrix_datapath.sv | 146 ++++++++++++++
 tb/tb_matrix_datapath.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_datapath.sv
// Matrix execute datapath: instruction decode, matrix register file and matrix ALU.
// One instruction is decoded and executed per cycle. The ALU result is written back
// on the next rising CLK edge. Matrices are WIDTH x WIDTH arrays of 32-bit elements,
// and element (r,c) sits at bits [(r*WIDTH+c)*32 +: 32].

// One output element of the matrix ALU.
// Each instance sees the operand slices it needs: the matching elements of rs1/rs2,
// the transposed rs1 element, and row r of rs1 with column c of rs2 for the product.
module matrix_elem_alu #(
  parameter int WIDTH = 2
) (
  input  logic [2:0]          op,
  input  logic [WIDTH*32-1:0] a_row,
  input  logic [WIDTH*32-1:0] b_col,
  input  logic [31:0]         a_el,
  input  logic [31:0]         a_tr,
  input  logic [31:0]         b_el,
  input  logic [31:0]         imm,
  output logic [31:0]         res
);

  logic [31:0] dot;

  // Row-by-column dot product; each product and the running sum keep the low 32 bits
  always_comb begin
    dot = '0;
    for (int k = 0; k < WIDTH; k++)
      dot = dot + a_row[k*32 +: 32] * b_col[k*32 +: 32];
  end

  // Select the element result by opcode; JUMP/HALT produce nothing meaningful
  always_comb begin
    res = '0;
    case (op)
      3'b000:  res = a_el + b_el;
      3'b001:  res = a_el - b_el;
      3'b010:  res = dot;
      3'b011:  res = a_tr;
      3'b100:  res = a_el * imm;
      3'b101:  res = a_el + imm;
      default: res = '0;
    endcase
  end

endmodule

module matrix_datapath #(
  parameter int WIDTH_BIT = 1,
  parameter int INDEX_BIT = 3,
  parameter int INSTR_BIT = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               en,
  input  logic [31:0]                        instruction,
  input  logic                               ld_en,
  input  logic [INDEX_BIT-1:0]               ld_idx,
  input  logic [(2**(2*WIDTH_BIT))*32-1:0]   ld_data,
  input  logic [INDEX_BIT-1:0]               dbg_idx,
  output logic [(2**(2*WIDTH_BIT))*32-1:0]   dbg_data,
  output logic                               pc_src,
  output logic [INSTR_BIT-1:0]               jump_addr,
  output logic                               done
);

  localparam int WIDTH = 2**WIDTH_BIT;
  localparam int NELEM = WIDTH*WIDTH;
  localparam int MAT_W = NELEM*32;
  localparam int NREG  = 2**INDEX_BIT;
  // Immediate occupies everything below the rs1 field
  localparam int IMM_W = 29 - 2*INDEX_BIT;

  logic [2:0]           op;
  logic [INDEX_BIT-1:0] wr_idx;
  logic [INDEX_BIT-1:0] rs1_idx;
  logic [INDEX_BIT-1:0] rs2_idx;
  logic [31:0]          imm;

  logic [NREG-1:0][MAT_W-1:0] mem_q;
  logic [NREG-1:0][MAT_W-1:0] mem_d;

  logic [MAT_W-1:0] rs1_m;
  logic [MAT_W-1:0] rs2_m;
  logic [MAT_W-1:0] alu_res;
  logic             wb_en;

  // Field extraction: register indices packed contiguously below the opcode
  always_comb begin
    op      = instruction[31:29];
    wr_idx  = instruction[28 -: INDEX_BIT];
    rs1_idx = instruction[28-INDEX_BIT -: INDEX_BIT];
    rs2_idx = instruction[28-2*INDEX_BIT -: INDEX_BIT];
    imm     = {{(32-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
  end

  // Control-flow decode stays live during reset and regardless of en
  always_comb begin
    pc_src    = (op == 3'b110);
    done      = (op == 3'b111);
    jump_addr = pc_src ? instruction[INSTR_BIT-1:0] : '0;
  end

  // Asynchronous operand and debug reads from the pre-edge register contents
  assign rs1_m    = mem_q[rs1_idx];
  assign rs2_m    = mem_q[rs2_idx];
  assign dbg_data = mem_q[dbg_idx];

  // One ALU slice per output element
  for (genvar r = 0; r < WIDTH; r++) begin : g_row
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      logic [WIDTH*32-1:0] b_col;
      for (genvar k = 0; k < WIDTH; k++) begin : g_k
        assign b_col[k*32 +: 32] = rs2_m[(k*WIDTH+c)*32 +: 32];
      end
      matrix_elem_alu #(.WIDTH(WIDTH)) u_alu (
        .op    (op),
        .a_row (rs1_m[r*WIDTH*32 +: WIDTH*32]),
        .b_col (b_col),
        .a_el  (rs1_m[(r*WIDTH+c)*32 +: 32]),
        .a_tr  (rs1_m[(c*WIDTH+r)*32 +: 32]),
        .b_el  (rs2_m[(r*WIDTH+c)*32 +: 32]),
        .imm   (imm),
        .res   (alu_res[(r*WIDTH+c)*32 +: 32])
      );
    end
  end

  // Only the six arithmetic opcodes write back
  assign wb_en = en && (op <= 3'b101);

  // Next register-file state: external load wins over any instruction write
  always_comb begin
    mem_d = mem_q;
    if (ld_en)
      mem_d[ld_idx] = ld_data;
    else if (wb_en)
      mem_d[wr_idx] = alu_res;
  end

  // Register file state; reset clears and holds every matrix at zero
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mem_q <= '0;
    else     mem_q <= mem_d;
  end

endmodule

// File: tb/tb_matrix_datapath.sv
// Scoreboard bench for matrix_datapath: the driver applies one cycle of stimulus per
// falling edge and queues the expected combinational outputs; the monitor compares
// them shortly after. Directed cases use literal expected matrices; the random phase
// relies on an element-level reference model of the register file.
module tb_matrix_datapath;

  logic         CLK;
  logic         RST;
  logic         en;
  logic [31:0]  instruction;
  logic         ld_en;
  logic [2:0]   ld_idx;
  logic [127:0] ld_data;
  logic [2:0]   dbg_idx;
  logic [127:0] dbg_data;
  logic         pc_src;
  logic [7:0]   jump_addr;
  logic         done;

  matrix_datapath #(.WIDTH_BIT(1), .INDEX_BIT(3), .INSTR_BIT(8)) dut (
    .CLK(CLK), .RST(RST), .en(en), .instruction(instruction),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data),
    .pc_src(pc_src), .jump_addr(jump_addr), .done(done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [127:0] dbg;
    logic         pc;
    logic [7:0]   ja;
    logic         dn;
    int           id;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          nstep    = 0;
  logic [31:0] rf[8][4];   // reference register file, element index r*2+c

  function automatic logic [127:0] mat(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] ir(input logic [2:0] op, w, a, b);
    return {op, w, a, b, 20'h0};
  endfunction

  function automatic logic [31:0] ii(input logic [2:0] op, w, a, input logic [22:0] im);
    return {op, w, a, im};
  endfunction

  function automatic logic [127:0] model_mat(input logic [2:0] i);
    logic [127:0] v;
    for (int e = 0; e < 4; e++) v[e*32 +: 32] = rf[i][e];
    return v;
  endfunction

  // One cycle: drive at the falling edge, queue expectations, advance the model
  task automatic step(input logic [31:0] ins_i, input logic en_i, input logic ld_i,
                      input logic [2:0] li, input logic [127:0] ldd, input logic [2:0] di,
                      input logic rst_i, input logic use_k, input logic [127:0] k);
    exp_t        e;
    logic [2:0]  op, w, a, b;
    logic [31:0] im;
    logic [31:0] t[4];
    @(negedge CLK);
    instruction = ins_i; en = en_i; ld_en = ld_i; ld_idx = li;
    ld_data = ldd; dbg_idx = di; RST = rst_i;
    if (rst_i)
      for (int i = 0; i < 8; i++) for (int x = 0; x < 4; x++) rf[i][x] = '0;
    op = ins_i[31:29]; w = ins_i[28:26]; a = ins_i[25:23]; b = ins_i[22:20];
    im = {{9{ins_i[22]}}, ins_i[22:0]};
    e.dbg = use_k ? k : model_mat(di);
    e.pc  = (op == 3'd6);
    e.ja  = (op == 3'd6) ? ins_i[7:0] : 8'h00;
    e.dn  = (op == 3'd7);
    e.id  = nstep;
    nstep++;
    q.push_back(e);
    if (!rst_i) begin
      if (ld_i) begin
        for (int x = 0; x < 4; x++) rf[li][x] = ldd[x*32 +: 32];
      end else if (en_i && op <= 3'd5) begin
        for (int r = 0; r < 2; r++) begin
          for (int c = 0; c < 2; c++) begin
            case (op)
              3'd0: t[r*2+c] = rf[a][r*2+c] + rf[b][r*2+c];
              3'd1: t[r*2+c] = rf[a][r*2+c] - rf[b][r*2+c];
              3'd2: t[r*2+c] = rf[a][r*2] * rf[b][c] + rf[a][r*2+1] * rf[b][2+c];
              3'd3: t[r*2+c] = rf[a][c*2+r];
              3'd4: t[r*2+c] = rf[a][r*2+c] * im;
              default: t[r*2+c] = rf[a][r*2+c] + im;
            endcase
          end
        end
        for (int x = 0; x < 4; x++) rf[w][x] = t[x];
      end
    end
  endtask

  task automatic ex(input logic [31:0] ins_i, input logic en_i, input logic [2:0] di);
    step(ins_i, en_i, 1'b0, 3'd0, '0, di, 1'b0, 1'b0, '0);
  endtask

  task automatic exk(input logic [31:0] ins_i, input logic en_i, input logic [2:0] di,
                     input logic [127:0] k);
    step(ins_i, en_i, 1'b0, 3'd0, '0, di, 1'b0, 1'b1, k);
  endtask

  task automatic ldm(input logic [2:0] li, input logic [127:0] ldd, input logic [2:0] di);
    step(32'h0, 1'b0, 1'b1, li, ldd, di, 1'b0, 1'b0, '0);
  endtask

  task automatic rs(input logic [2:0] di);
    step(32'h0, 1'b0, 1'b0, 3'd0, '0, di, 1'b1, 1'b1, '0);
  endtask

  // Monitor: compare queued expectations against the settled combinational outputs
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (dbg_data !== e.dbg) begin
          failures++;
          $display("FAIL dbg step %0d idx %0d: got %h want %h", e.id, dbg_idx, dbg_data, e.dbg);
        end
        checks++;
        if (pc_src !== e.pc) begin
          failures++;
          $display("FAIL pc_src step %0d: got %b want %b", e.id, pc_src, e.pc);
        end
        checks++;
        if (jump_addr !== e.ja) begin
          failures++;
          $display("FAIL jump_addr step %0d: got %h want %h", e.id, jump_addr, e.ja);
        end
        checks++;
        if (done !== e.dn) begin
          failures++;
          $display("FAIL done step %0d: got %b want %b", e.id, done, e.dn);
        end
      end
    end
  end

  initial begin : drv
    logic [127:0] ma, mb, mx, mf;
    logic [31:0]  ins_r;
    RST = 1'b1; en = 1'b0; instruction = '0; ld_en = 1'b0;
    ld_idx = '0; ld_data = '0; dbg_idx = '0;
    for (int i = 0; i < 8; i++) for (int x = 0; x < 4; x++) rf[i][x] = '0;

    ma = mat(1, 2, 3, 4);
    mb = mat(5, 6, 7, 8);
    mf = mat(32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE);

    // Reset state, then a reset pulse after loads reads zero before any edge
    rs(3'd0);
    ldm(3'd1, ma, 3'd0);
    ldm(3'd2, mb, 3'd1);
    for (int i = 0; i < 8; i++) rs(3'(i));

    // Matrix product and elementwise subtract
    ldm(3'd1, ma, 3'd0);
    step(32'h0, 1'b0, 1'b1, 3'd2, mb, 3'd1, 1'b0, 1'b1, ma);
    exk(ir(3'd2, 3'd3, 3'd1, 3'd2), 1'b1, 3'd2, mb);
    exk(ir(3'd1, 3'd4, 3'd1, 3'd2), 1'b1, 3'd3, mat(19, 22, 43, 50));
    exk(32'h0, 1'b0, 3'd4, mat(32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC));

    // Transpose, then self-overwrite with ADDI -1
    ldm(3'd1, ma, 3'd0);
    exk(ir(3'd3, 3'd5, 3'd1, 3'd0), 1'b1, 3'd1, ma);
    exk(ii(3'd5, 3'd1, 3'd1, 23'h7FFFFF), 1'b1, 3'd5, mat(1, 3, 2, 4));
    exk(32'h0, 1'b0, 3'd1, mat(0, 1, 2, 3));

    // Wrapping add and scale; jump/halt must not write r3
    ldm(3'd1, mat(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 3'd0);
    ex(ir(3'd0, 3'd2, 3'd1, 3'd1), 1'b1, 3'd1);
    exk(ii(3'd4, 3'd3, 3'd1, 23'd2), 1'b1, 3'd2, mf);
    exk({3'b110, 3'd3, 18'd0, 8'h2C}, 1'b1, 3'd3, mf);
    exk({3'b111, 3'd3, 26'd0}, 1'b1, 3'd3, mf);
    exk(32'h0, 1'b0, 3'd3, mf);

    // Load beats a same-edge instruction write; en=0 suppresses writeback
    mx = mat(11, 22, 33, 44);
    step(ir(3'd0, 3'd7, 3'd1, 3'd1), 1'b1, 1'b1, 3'd6, mx, 3'd7, 1'b0, 1'b1, '0);
    exk(ir(3'd0, 3'd7, 3'd1, 3'd1), 1'b0, 3'd6, mx);
    exk(32'h0, 1'b0, 3'd7, '0);

    // Random phase against the reference model
    for (int n = 0; n < 400; n++) begin
      ins_r = $urandom;
      mx = {$urandom, $urandom, $urandom, $urandom};
      step(ins_r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), mx, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 49) == 0), 1'b0, '0);
    end
    ex(32'h0, 1'b0, 3'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
